// File: rtl/safety_island_boot_ctrl.sv
// Boot sequencer for the safety-island core: holds the core in reset, then releases it
// to the boot ROM (Jtag) or to a host-preloaded image after validating its boot address.
module safety_island_boot_ctrl #(
  parameter int unsigned CoreRstCycles  = 8,
  parameter logic [31:0] PreloadTimeout = 32'd65536,
  parameter logic [31:0] JtagBootAddr   = 32'h0000_1080,
  parameter logic [31:0] MemStart       = 32'h0001_0000,
  parameter logic [31:0] MemEnd         = 32'h0003_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  bootmode_i,
  input  logic        fetch_en_i,
  input  logic [31:0] boot_addr_i,
  input  logic        preload_done_i,
  input  logic        sw_rst_req_i,
  output logic        core_rst_no,
  output logic        core_fetch_en_o,
  output logic [31:0] core_boot_addr_o,
  output logic [2:0]  state_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    RST_HOLD     = 3'd0,
    SAMPLE       = 3'd1,
    WAIT_PRELOAD = 3'd2,
    CHECK        = 3'd3,
    RUN          = 3'd4,
    ERROR        = 3'd5
  } state_e;

  localparam logic [1:0]  BootPreloaded = 2'b01;
  localparam logic [31:0] RstLast       = 32'(CoreRstCycles - 1);
  localparam logic [31:0] TimeoutLast   = PreloadTimeout - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_d;
  logic        err_d;
  logic [1:0]  code_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = core_boot_addr_o;
    err_d   = err_o;
    code_d  = err_code_o;
    // A software restart overrides everything except an ongoing reset hold.
    if (sw_rst_req_i && (state_q != RST_HOLD)) begin
      state_d = RST_HOLD;
      err_d   = 1'b0;
      code_d  = 2'd0;
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (cnt_q == RstLast) state_d = SAMPLE;
          else                  cnt_d   = cnt_q + 32'd1;
        end
        SAMPLE: begin
          if (bootmode_i == BootPreloaded) begin
            state_d = WAIT_PRELOAD;
          end else begin
            state_d = RUN;
            addr_d  = JtagBootAddr;
          end
        end
        WAIT_PRELOAD: begin
          if (preload_done_i && fetch_en_i) begin
            state_d = CHECK;
          end else if ((PreloadTimeout != 32'd0) && (cnt_q == TimeoutLast)) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        CHECK: begin
          if (boot_addr_i[1:0] != 2'b00) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = 2'd2;
          end else if ((boot_addr_i < MemStart) || (boot_addr_i >= MemEnd)) begin
            state_d = ERROR;
            err_d   = 1'b1;
            code_d  = 2'd3;
          end else begin
            state_d = RUN;
            addr_d  = boot_addr_i;
          end
        end
        RUN, ERROR: begin
          state_d = state_q;
        end
        default: state_d = RST_HOLD;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from next_state so they change together with the state flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= RST_HOLD;
      cnt_q            <= '0;
      core_rst_no      <= 1'b0;
      core_fetch_en_o  <= 1'b0;
      core_boot_addr_o <= JtagBootAddr;
      err_o            <= 1'b0;
      err_code_o       <= 2'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      core_rst_no      <= !((state_d == RST_HOLD) || (state_d == ERROR));
      core_fetch_en_o  <= (state_d == RUN);
      core_boot_addr_o <= addr_d;
      err_o            <= err_d;
      err_code_o       <= code_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_safety_island_boot_ctrl.sv
// Self-checking bench for safety_island_boot_ctrl; expected output bundles are queued
// as stimulus is applied and compared after each clock edge.
module tb_safety_island_boot_ctrl;

  localparam logic [2:0]  S_HOLD   = 3'd0;
  localparam logic [2:0]  S_SAMPLE = 3'd1;
  localparam logic [2:0]  S_WAIT   = 3'd2;
  localparam logic [2:0]  S_CHECK  = 3'd3;
  localparam logic [2:0]  S_RUN    = 3'd4;
  localparam logic [2:0]  S_ERR    = 3'd5;
  localparam logic [31:0] JTAG     = 32'h0000_1080;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  bootmode_i = 2'b00;
  logic        fetch_en_i = 1'b0;
  logic [31:0] boot_addr_i = '0;
  logic        preload_done_i = 1'b0;
  logic        sw_rst_req_i = 1'b0;
  logic        core_rst_no;
  logic        core_fetch_en_o;
  logic [31:0] core_boot_addr_o;
  logic [2:0]  state_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  typedef struct {
    string       name;
    logic [39:0] outs;
  } exp_t;

  typedef struct {
    int          hs;
    logic [31:0] addr;
    logic        run_ok;
    logic [1:0]  code;
  } pre_case_t;

  exp_t        exp_q[$];
  exp_t        got;
  int          total = 0;
  int          bad = 0;
  logic [31:0] cur_addr = JTAG;
  logic [39:0] obs;

  safety_island_boot_ctrl #(.PreloadTimeout(32'd16)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .bootmode_i       (bootmode_i),
    .fetch_en_i       (fetch_en_i),
    .boot_addr_i      (boot_addr_i),
    .preload_done_i   (preload_done_i),
    .sw_rst_req_i     (sw_rst_req_i),
    .core_rst_no      (core_rst_no),
    .core_fetch_en_o  (core_fetch_en_o),
    .core_boot_addr_o (core_boot_addr_o),
    .state_o          (state_o),
    .err_o            (err_o),
    .err_code_o       (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs = {core_rst_no, core_fetch_en_o, core_boot_addr_o, state_o, err_o, err_code_o};

  function automatic logic [39:0] pk(logic r, logic f, logic [31:0] a, logic [2:0] s,
                                     logic e, logic [1:0] c);
    return {r, f, a, s, e, c};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [39:0] e;
    rst_ni = 1'b0;
    repeat (3) tick();
    exp_q.push_back('{name: "reset_values", outs: pk(0, 0, JTAG, S_HOLD, 0, 0)});
    got = exp_q.pop_front();
    total++;
    if (obs !== got.outs) begin
      bad++;
      $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
    end
    rst_ni = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      // Once running, register changes must not disturb the core.
      if (k >= 10) begin
        bootmode_i = 2'b01; fetch_en_i = 1'b1; preload_done_i = 1'b1; boot_addr_i = 32'h0002_0000;
      end
      if (k <= 7)      e = pk(0, 0, JTAG, S_HOLD, 0, 0);
      else if (k == 8) e = pk(1, 0, JTAG, S_SAMPLE, 0, 0);
      else             e = pk(1, 1, JTAG, S_RUN, 0, 0);
      exp_q.push_back('{name: $sformatf("reset_seq k=%0d", k), outs: e});
      tick();
      got = exp_q.pop_front();
      total++;
      if (obs !== got.outs) begin
        bad++;
        $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
      end
    end
    fetch_en_i = 1'b0; preload_done_i = 1'b0;
    cur_addr = JTAG;
  endtask

  task automatic test_preload();
    pre_case_t   cases [8];
    logic [39:0] e;
    int          final_k;
    cases = '{'{14, 32'h0001_0080, 1'b1, 2'd0},
              '{12, 32'h0001_0082, 1'b0, 2'd2},
              '{12, 32'h0003_0000, 1'b0, 2'd3},
              '{12, 32'h0002_FFFC, 1'b1, 2'd0},
              '{12, 32'h0000_FFFC, 1'b0, 2'd3},
              '{12, 32'h0003_0002, 1'b0, 2'd2},
              '{0,  32'h0001_0000, 1'b0, 2'd1},
              '{25, 32'h0001_0000, 1'b1, 2'd0}};
    for (int i = 0; i < 8; i++) begin
      // hs==0 means no handshake: the 16-cycle timeout fires at k=25.
      final_k = (cases[i].hs != 0) ? cases[i].hs + 1 : 25;
      for (int k = 0; k <= final_k + 1; k++) begin
        sw_rst_req_i   = (k == 0);
        bootmode_i     = (k > final_k) ? 2'b00 : 2'b01;
        preload_done_i = (cases[i].hs != 0) && ((k == cases[i].hs) || (k == cases[i].hs - 1));
        fetch_en_i     = (cases[i].hs != 0) && (k == cases[i].hs);
        boot_addr_i    = (k > final_k) ? 32'hDEAD_BEE0 : cases[i].addr;
        if (k <= 7)                                e = pk(0, 0, cur_addr, S_HOLD, 0, 0);
        else if (k == 8)                           e = pk(1, 0, cur_addr, S_SAMPLE, 0, 0);
        else if (cases[i].hs != 0 && k == cases[i].hs) e = pk(1, 0, cur_addr, S_CHECK, 0, 0);
        else if (k < final_k)                      e = pk(1, 0, cur_addr, S_WAIT, 0, 0);
        else if (cases[i].run_ok)                  e = pk(1, 1, cases[i].addr, S_RUN, 0, 0);
        else                                       e = pk(0, 0, cur_addr, S_ERR, 1, cases[i].code);
        exp_q.push_back('{name: $sformatf("preload%0d k=%0d", i, k), outs: e});
        tick();
        got = exp_q.pop_front();
        total++;
        if (obs !== got.outs) begin
          bad++;
          $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
        end
      end
      if (cases[i].run_ok) cur_addr = cases[i].addr;
    end
    sw_rst_req_i = 1'b0; preload_done_i = 1'b0; fetch_en_i = 1'b0;
  endtask

  task automatic test_bootmodes();
    logic [1:0]  modes [3];
    logic [39:0] e;
    modes = '{2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k <= 9; k++) begin
        sw_rst_req_i = (k == 0);
        bootmode_i   = modes[i];
        if (k <= 7)      e = pk(0, 0, cur_addr, S_HOLD, 0, 0);
        else if (k == 8) e = pk(1, 0, cur_addr, S_SAMPLE, 0, 0);
        else             e = pk(1, 1, JTAG, S_RUN, 0, 0);
        exp_q.push_back('{name: $sformatf("bootmode%0d k=%0d", modes[i], k), outs: e});
        tick();
        got = exp_q.pop_front();
        total++;
        if (obs !== got.outs) begin
          bad++;
          $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
        end
      end
      cur_addr = JTAG;
    end
    sw_rst_req_i = 1'b0;
  endtask

  task automatic test_sw_rst();
    logic [39:0] e;
    boot_addr_i = 32'h0002_0000;
    bootmode_i  = 2'b01;
    for (int k = 0; k <= 24; k++) begin
      // k=4: ignored during hold; k=12: restart wins over a simultaneous handshake.
      sw_rst_req_i   = (k == 0) || (k == 4) || (k == 12);
      preload_done_i = (k == 12) || (k == 23);
      fetch_en_i     = (k == 12) || (k == 23);
      if (k <= 7)       e = pk(0, 0, cur_addr, S_HOLD, 0, 0);
      else if (k == 8)  e = pk(1, 0, cur_addr, S_SAMPLE, 0, 0);
      else if (k <= 11) e = pk(1, 0, cur_addr, S_WAIT, 0, 0);
      else if (k <= 19) e = pk(0, 0, cur_addr, S_HOLD, 0, 0);
      else if (k == 20) e = pk(1, 0, cur_addr, S_SAMPLE, 0, 0);
      else if (k <= 22) e = pk(1, 0, cur_addr, S_WAIT, 0, 0);
      else if (k == 23) e = pk(1, 0, cur_addr, S_CHECK, 0, 0);
      else              e = pk(1, 1, 32'h0002_0000, S_RUN, 0, 0);
      exp_q.push_back('{name: $sformatf("sw_rst k=%0d", k), outs: e});
      tick();
      got = exp_q.pop_front();
      total++;
      if (obs !== got.outs) begin
        bad++;
        $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
      end
    end
    cur_addr = 32'h0002_0000;
    sw_rst_req_i = 1'b0; preload_done_i = 1'b0; fetch_en_i = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [39:0] e;
    bootmode_i = 2'b01;
    for (int k = 0; k <= 12; k++) begin
      sw_rst_req_i = (k == 0);
      if (k <= 7)      e = pk(0, 0, cur_addr, S_HOLD, 0, 0);
      else if (k == 8) e = pk(1, 0, cur_addr, S_SAMPLE, 0, 0);
      else             e = pk(1, 0, cur_addr, S_WAIT, 0, 0);
      exp_q.push_back('{name: $sformatf("async_pre k=%0d", k), outs: e});
      tick();
      got = exp_q.pop_front();
      total++;
      if (obs !== got.outs) begin
        bad++;
        $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
      end
    end
    sw_rst_req_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    exp_q.push_back('{name: "async_reset_no_edge", outs: pk(0, 0, JTAG, S_HOLD, 0, 0)});
    got = exp_q.pop_front();
    total++;
    if (obs !== got.outs) begin
      bad++;
      $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
    end
    tick();
    rst_ni = 1'b1;
    bootmode_i = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 7)      e = pk(0, 0, JTAG, S_HOLD, 0, 0);
      else if (k == 8) e = pk(1, 0, JTAG, S_SAMPLE, 0, 0);
      else             e = pk(1, 1, JTAG, S_RUN, 0, 0);
      exp_q.push_back('{name: $sformatf("async_post k=%0d", k), outs: e});
      tick();
      got = exp_q.pop_front();
      total++;
      if (obs !== got.outs) begin
        bad++;
        $display("FAIL %s got=%h want=%h", got.name, obs, got.outs);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_bootmodes();
    test_sw_rst();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
